fir_mac_scheduler: RTL and testbench

FIR_MAC_SCHEDULER -- requirements
Module: fir_mac_scheduler

---
 rtl/fir_mac_scheduler.sv | 155 +++++++++++++++
 tb/tb_fir_mac_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_scheduler.sv
// Stereo 3-tap FIR sharing one 16x16 multiplier and one 34-bit accumulator across both channels.
// Define FIR_COEF_WR_EN to add runtime coefficient writes through shadow registers.
module fir_mac_scheduler #(
  parameter logic signed [15:0] COEF0_INIT = 16'sh2000,
  parameter logic signed [15:0] COEF1_INIT = 16'sh4000,
  parameter logic signed [15:0] COEF2_INIT = 16'sh2000
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic signed [15:0] AUD_IN_L,
  input  logic signed [15:0] AUD_IN_R,
  input  logic               IN_VALID,
  output logic               IN_READY,
`ifdef FIR_COEF_WR_EN
  input  logic               COEF_WE,
  input  logic [1:0]         COEF_ADDR,
  input  logic signed [15:0] COEF_DATA,
`endif
  output logic signed [15:0] AUD_OUT_L,
  output logic signed [15:0] AUD_OUT_R,
  output logic               OUT_VALID,
  output logic               OVERRUN
);

  typedef enum logic [1:0] {S_IDLE, S_MAC_L, S_MAC_R, S_DONE} state_t;

  state_t             r_state, w_state_next;
  logic [1:0]         r_tap;
  logic signed [33:0] r_acc;
  logic signed [15:0] r_dl0, r_dl1, r_dl2;
  logic signed [15:0] r_dr0, r_dr1, r_dr2;
  logic signed [15:0] r_hold_l, r_out_l, r_out_r;
  logic               r_out_valid, r_overrun;
  logic signed [15:0] w_coef [3];
  logic signed [15:0] w_sample, w_coef_sel;
  logic signed [31:0] w_prod;
  logic signed [33:0] w_acc_sum;
  logic               w_accept, w_mac;

  assign IN_READY  = (r_state == S_IDLE);
  assign w_accept  = IN_VALID && (r_state == S_IDLE);
  assign w_mac     = (r_state == S_MAC_L) || (r_state == S_MAC_R);
  assign AUD_OUT_L = r_out_l;
  assign AUD_OUT_R = r_out_r;
  assign OUT_VALID = r_out_valid;
  assign OVERRUN   = r_overrun;

  // The active set is latched at acceptance so a mid-sample write cannot split taps.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_coef
      localparam logic signed [15:0] C_INIT = (gi == 0) ? COEF0_INIT :
                                              (gi == 1) ? COEF1_INIT : COEF2_INIT;
`ifdef FIR_COEF_WR_EN
      logic signed [15:0] r_shadow, r_active;
      always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
          r_shadow <= C_INIT;
          r_active <= C_INIT;
        end else begin
          if (COEF_WE && (COEF_ADDR == 2'(gi))) r_shadow <= COEF_DATA;
          if (w_accept) r_active <= r_shadow;
        end
      end
      assign w_coef[gi] = r_active;
`else
      assign w_coef[gi] = C_INIT;
`endif
    end
  endgenerate

  function automatic logic signed [15:0] sat16(input logic signed [33:0] a);
    logic signed [18:0] s;
    s = a[33:15];
    if (s > 19'sd32767)       return 16'sh7FFF;
    else if (s < -19'sd32768) return 16'sh8000;
    else                      return s[15:0];
  endfunction

  always_comb begin
    w_sample   = 16'sd0;
    w_coef_sel = 16'sd0;
    case (r_tap)
      2'd0: begin
        w_sample   = (r_state == S_MAC_R) ? r_dr0 : r_dl0;
        w_coef_sel = w_coef[0];
      end
      2'd1: begin
        w_sample   = (r_state == S_MAC_R) ? r_dr1 : r_dl1;
        w_coef_sel = w_coef[1];
      end
      2'd2: begin
        w_sample   = (r_state == S_MAC_R) ? r_dr2 : r_dl2;
        w_coef_sel = w_coef[2];
      end
      default: ;
    endcase
  end

  assign w_prod    = w_sample * w_coef_sel;
  assign w_acc_sum = ((r_tap == 2'd0) ? 34'sd0 : r_acc) + $signed({{2{w_prod[31]}}, w_prod});

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_MAC_L;
      S_MAC_L: if (r_tap == 2'd2) w_state_next = S_MAC_R;
      S_MAC_R: if (r_tap == 2'd2) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_tap       <= 2'd0;
      r_acc       <= 34'sd0;
      r_dl0       <= 16'sd0;
      r_dl1       <= 16'sd0;
      r_dl2       <= 16'sd0;
      r_dr0       <= 16'sd0;
      r_dr1       <= 16'sd0;
      r_dr2       <= 16'sd0;
      r_hold_l    <= 16'sd0;
      r_out_l     <= 16'sd0;
      r_out_r     <= 16'sd0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= (r_state == S_DONE);
      if (IN_VALID && !IN_READY) r_overrun <= 1'b1;
      if (w_accept) begin
        r_dl2 <= r_dl1;
        r_dl1 <= r_dl0;
        r_dl0 <= AUD_IN_L;
        r_dr2 <= r_dr1;
        r_dr1 <= r_dr0;
        r_dr0 <= AUD_IN_R;
      end
      if (w_mac) begin
        r_tap <= (r_tap == 2'd2) ? 2'd0 : r_tap + 2'd1;
        r_acc <= w_acc_sum;
      end else begin
        r_tap <= 2'd0;
      end
      if ((r_state == S_MAC_L) && (r_tap == 2'd2)) r_hold_l <= sat16(w_acc_sum);
      if (r_state == S_DONE) begin
        r_out_l <= r_hold_l;
        r_out_r <= sat16(r_acc);
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Scoreboard bench for fir_mac_scheduler: directed strobes push expected outputs, a monitor pops on OUT_VALID.
// Coefficient-write scenarios run only when FIR_COEF_WR_EN is defined.
module tb_fir_mac_scheduler;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic [15:0] in_l, in_r;
  logic        in_ready;
  logic [15:0] out_l, out_r;
  logic        out_valid;
  logic        overrun;
`ifdef FIR_COEF_WR_EN
  logic        coef_we;
  logic [1:0]  coef_addr;
  logic [15:0] coef_data;
`endif

  fir_mac_scheduler dut (
    .CLOCK_50  (clk),
    .RESET     (rst),
    .AUD_IN_L  (in_l),
    .AUD_IN_R  (in_r),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
`ifdef FIR_COEF_WR_EN
    .COEF_WE   (coef_we),
    .COEF_ADDR (coef_addr),
    .COEF_DATA (coef_data),
`endif
    .AUD_OUT_L (out_l),
    .AUD_OUT_R (out_r),
    .OUT_VALID (out_valid),
    .OVERRUN   (overrun)
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          n;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every OUT_VALID must match the oldest outstanding expectation, 8 cycles after its strobe.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        $display("txn %s: L=%h R=%h (expect L=%h R=%h) latency=%0d", e.tag, out_l, out_r, e.l, e.r, cyc - e.n);
        chk({e.tag, "_L"}, 32'(out_l), 32'(e.l));
        chk({e.tag, "_R"}, 32'(out_r), 32'(e.r));
        chk({e.tag, "_latency"}, 32'(cyc - e.n), 32'd8);
        chk({e.tag, "_ready"}, 32'(in_ready), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for IN_READY, drives a one-cycle strobe and optionally records the expected response.
  task automatic strobe(input logic [15:0] l, input logic [15:0] r, input bit expect_out,
                        input logic [15:0] el, input logic [15:0] er, input string tag);
    int w;
    w = 0;
    tick();
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout actual=0 required=1", tag);
      return;
    end
    in_l     = l;
    in_r     = r;
    in_valid = 1'b1;
    if (expect_out) q.push_back('{el, er, cyc, tag});
`ifdef FIR_COEF_WR_EN
    if (tag == "cw1") begin
      coef_we   = 1'b1;
      coef_addr = 2'd0;
      coef_data = 16'h0000;
    end
`endif
    tick();
    in_valid = 1'b0;
`ifdef FIR_COEF_WR_EN
    coef_we = 1'b0;
`endif
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while (q.size() != 0 && w < 100) begin
      tick();
      w++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout actual=%0d required=0", tag, q.size());
      q.delete();
    end
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

`ifdef FIR_COEF_WR_EN
  task automatic coef_write(input logic [1:0] a, input logic [15:0] d);
    tick();
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    tick();
    coef_we   = 1'b0;
  endtask
`endif

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_l     = 16'h0;
    in_r     = 16'h0;
`ifdef FIR_COEF_WR_EN
    coef_we   = 1'b0;
    coef_addr = 2'd0;
    coef_data = 16'h0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_ready",    32'(in_ready),  32'd1);
    chk("rst_valid",    32'(out_valid), 32'd0);
    chk("rst_out_l",    32'(out_l),     32'd0);
    chk("rst_out_r",    32'(out_r),     32'd0);
    chk("rst_overrun",  32'(overrun),   32'd0);

    // Impulse through default taps 0.25/0.5/0.25.
    strobe(16'h4000, 16'h0000, 1'b1, 16'h1000, 16'h0000, "imp0");
    strobe(16'h0000, 16'h0000, 1'b1, 16'h2000, 16'h0000, "imp1");
    strobe(16'h0000, 16'h0000, 1'b1, 16'h1000, 16'h0000, "imp2");
    strobe(16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, "imp3");
    drain("imp");
    chk("imp_overrun", 32'(overrun), 32'd0);

    // Overrun: a strobe 3 cycles after acceptance must be dropped.
    strobe(16'h4000, 16'h0100, 1'b1, 16'h1000, 16'h0040, "ovr1");
    tick();
    tick();
    in_l     = 16'h7FFF;
    in_r     = 16'h7FFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    strobe(16'h0000, 16'h0000, 1'b1, 16'h2000, 16'h0080, "ovr2");
    drain("ovr");
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Reset in cycle N+4 aborts the sample.
    strobe(16'h4000, 16'h4000, 1'b0, 16'h0, 16'h0, "abort");
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready",   32'(in_ready), 32'd1);
    chk("abort_out_l",   32'(out_l),    32'd0);
    chk("abort_out_r",   32'(out_r),    32'd0);
    chk("abort_overrun", 32'(overrun),  32'd0);
    repeat (12) tick();
    strobe(16'h4000, 16'h0000, 1'b1, 16'h1000, 16'h0000, "rimp0");
    strobe(16'h0000, 16'h0000, 1'b1, 16'h2000, 16'h0000, "rimp1");
    strobe(16'h0000, 16'h0000, 1'b1, 16'h1000, 16'h0000, "rimp2");
    strobe(16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, "rimp3");
    drain("rimp");

`ifdef FIR_COEF_WR_EN
    // COEF0=0 written in the acceptance cycle applies only from the next sample.
    strobe(16'h4000, 16'h0000, 1'b1, 16'h1000, 16'h0000, "cw1");
    strobe(16'h0000, 16'h0000, 1'b1, 16'h2000, 16'h0000, "cw2");
    strobe(16'h0000, 16'h0000, 1'b1, 16'h1000, 16'h0000, "cw3");
    strobe(16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, "cw4");
    strobe(16'h4000, 16'h0000, 1'b1, 16'h0000, 16'h0000, "cw5");
    strobe(16'h0000, 16'h0000, 1'b1, 16'h2000, 16'h0000, "cw6");
    drain("cw");

    // Saturation with all taps at 0x7FFF; the index-3 write must be ignored.
    do_reset();
    coef_write(2'd0, 16'h7FFF);
    coef_write(2'd1, 16'h7FFF);
    coef_write(2'd2, 16'h7FFF);
    coef_write(2'd3, 16'h0000);
    strobe(16'h7FFF, 16'h0000, 1'b1, 16'h7FFE, 16'h0000, "psat1");
    strobe(16'h7FFF, 16'h0000, 1'b1, 16'h7FFF, 16'h0000, "psat2");
    strobe(16'h7FFF, 16'h0000, 1'b1, 16'h7FFF, 16'h0000, "psat3");
    strobe(16'h0000, 16'h8000, 1'b1, 16'h7FFF, 16'h8001, "nsat1");
    strobe(16'h0000, 16'h8000, 1'b1, 16'h7FFE, 16'h8000, "nsat2");
    strobe(16'h0000, 16'h8000, 1'b1, 16'h0000, 16'h8000, "nsat3");
    drain("sat");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
